ast_width_reducer: RTL and testbench



---
 rtl/ast_width_pkg.sv | 18 +
 rtl/ast_skid_buf.sv | 44 ++++
 rtl/ast_width_reducer.sv | 146 ++++++++++++++
 tb/tb_ast_width_reducer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ast_width_pkg.sv
// Shared types and sizing helpers for the Avalon-ST width converters.
package ast_width_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   function automatic int calc_ratio(input int in_w, input int out_w);
      return in_w / out_w;
   endfunction

   // Narrow beats needed to carry the valid bytes of an eop word.
   function automatic int beats_for_eop(input int empty, input int wi, input int wo);
      return (wi - empty + wo - 1) / wo;
   endfunction

endpackage

// File: rtl/ast_skid_buf.sv
// One-entry valid/ready skid register; in_rdy_o is registered (entry empty).
// Zero latency when empty; a word that meets backpressure is parked for one extra cycle.
module ast_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             in_vld_i,
   input  logic [WIDTH-1:0] in_dat_i,
   output logic             in_rdy_o,
   output logic             out_vld_o,
   output logic [WIDTH-1:0] out_dat_o,
   input  logic             out_rdy_i
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] dat_q, dat_d;

   assign in_rdy_o  = ~full_q & ~srst_i;
   assign out_vld_o = full_q | in_vld_i;
   assign out_dat_o = full_q ? dat_q : in_dat_i;

   always_comb begin
      full_d = full_q;
      dat_d  = dat_q;
      if (full_q) begin
         if (out_rdy_i) full_d = 1'b0;
      end else if (in_vld_i && !out_rdy_i) begin
         full_d = 1'b1;
         dat_d  = in_dat_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         full_q <= 1'b0;
         dat_q  <= '0;
      end else begin
         full_q <= full_d;
         dat_q  <= dat_d;
      end
   end

endmodule

// File: rtl/ast_width_reducer.sv
// Avalon-ST down-converter: wide beats out as DATA_IN_W/DATA_OUT_W narrow beats, first beat 1 cycle after accept.
// Optional AST_WIDTH_REDUCER_SKID_EN adds a skid register so ast_ready_o no longer depends on ast_ready_i.
module ast_width_reducer
   import ast_width_pkg::*;
#(
   parameter int DATA_IN_W   = 256,
   parameter int EMPTY_IN_W  = ($clog2(DATA_IN_W / 8) > 0) ? $clog2(DATA_IN_W / 8) : 1,
   parameter int DATA_OUT_W  = 64,
   parameter int EMPTY_OUT_W = ($clog2(DATA_OUT_W / 8) > 0) ? $clog2(DATA_OUT_W / 8) : 1,
   parameter int CHANNEL_W   = 10
) (
   input  logic                   clk_i,
   input  logic                   srst_i,
   input  logic [DATA_IN_W-1:0]   ast_data_i,
   input  logic                   ast_startofpacket_i,
   input  logic                   ast_endofpacket_i,
   input  logic                   ast_valid_i,
   input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
   input  logic [CHANNEL_W-1:0]   ast_channel_i,
   output logic                   ast_ready_o,
   output logic [DATA_OUT_W-1:0]  ast_data_o,
   output logic                   ast_startofpacket_o,
   output logic                   ast_endofpacket_o,
   output logic                   ast_valid_o,
   output logic [EMPTY_OUT_W-1:0] ast_empty_o,
   output logic [CHANNEL_W-1:0]   ast_channel_o,
   input  logic                   ast_ready_i
);

   localparam int R     = calc_ratio(DATA_IN_W, DATA_OUT_W);
   localparam int WI    = DATA_IN_W / 8;
   localparam int WO    = DATA_OUT_W / 8;
   localparam int IDX_W = (R > 1) ? $clog2(R) : 1;

   typedef struct packed {
      logic [DATA_IN_W-1:0]  data;
      logic                  sop;
      logic                  eop;
      logic [EMPTY_IN_W-1:0] empty;
      logic [CHANNEL_W-1:0]  channel;
   } word_t;

   localparam int WORD_W = $bits(word_t);

   word_t      in_word, core_word;
   logic       core_vld, core_rdy;

   state_e     state_q, state_d;
   word_t      buf_q, buf_d;
   logic [IDX_W-1:0] idx_q, idx_d, last_idx;
   logic       is_last;
   int         n_beats;

   assign in_word = '{data:    ast_data_i,
                      sop:     ast_startofpacket_i,
                      eop:     ast_endofpacket_i,
                      empty:   ast_empty_i,
                      channel: ast_channel_i};

`ifdef AST_WIDTH_REDUCER_SKID_EN
   logic [WORD_W-1:0] skid_dat;

   ast_skid_buf #(
      .WIDTH(WORD_W)
   ) u_skid (
      .clk_i     (clk_i),
      .srst_i    (srst_i),
      .in_vld_i  (ast_valid_i),
      .in_dat_i  (in_word),
      .in_rdy_o  (ast_ready_o),
      .out_vld_o (core_vld),
      .out_dat_o (skid_dat),
      .out_rdy_i (core_rdy)
   );

   assign core_word = word_t'(skid_dat);
`else
   assign core_vld    = ast_valid_i;
   assign core_word   = in_word;
   assign ast_ready_o = core_rdy & ~srst_i;
`endif

   // Eop words stop at the last narrow beat holding a valid byte.
   always_comb begin
      n_beats  = buf_q.eop ? beats_for_eop(int'(buf_q.empty), WI, WO) : R;
      last_idx = IDX_W'(n_beats - 1);
      is_last  = (idx_q == last_idx);
   end

   always_comb begin
      state_d             = state_q;
      buf_d               = buf_q;
      idx_d               = idx_q;
      core_rdy            = 1'b0;
      ast_valid_o         = 1'b0;
      ast_startofpacket_o = 1'b0;
      ast_endofpacket_o   = 1'b0;
      ast_empty_o         = '0;
      ast_data_o          = buf_q.data[int'(idx_q) * DATA_OUT_W +: DATA_OUT_W];
      ast_channel_o       = buf_q.channel;

      case (state_q)
         ST_IDLE: begin
            core_rdy = 1'b1;
            if (core_vld) begin
               buf_d   = core_word;
               idx_d   = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            ast_valid_o         = 1'b1;
            ast_startofpacket_o = buf_q.sop & (idx_q == '0);
            ast_endofpacket_o   = buf_q.eop & is_last;
            if (ast_endofpacket_o)
               ast_empty_o = EMPTY_OUT_W'(n_beats * WO - (WI - int'(buf_q.empty)));
            // Accept the next wide word only as the last narrow beat leaves.
            core_rdy = ast_ready_i & is_last;
            if (ast_ready_i) begin
               if (!is_last) begin
                  idx_d = idx_q + IDX_W'(1);
               end else if (core_vld) begin
                  buf_d = core_word;
                  idx_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q <= ST_IDLE;
         buf_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_ast_width_reducer.sv
// Scoreboard bench for ast_width_reducer (default build, 256 -> 64 bit).
module tb_ast_width_reducer;

   logic         clk = 1'b0;
   logic         srst_i = 1'b1;
   logic [255:0] ast_data_i = '0;
   logic         ast_startofpacket_i = 1'b0;
   logic         ast_endofpacket_i = 1'b0;
   logic         ast_valid_i = 1'b0;
   logic [4:0]   ast_empty_i = '0;
   logic [9:0]   ast_channel_i = '0;
   logic         ast_ready_o;
   logic [63:0]  ast_data_o;
   logic         ast_startofpacket_o;
   logic         ast_endofpacket_o;
   logic         ast_valid_o;
   logic [2:0]   ast_empty_o;
   logic [9:0]   ast_channel_o;
   logic         ast_ready_i = 1'b1;

   ast_width_reducer dut (
      .clk_i               (clk),
      .srst_i              (srst_i),
      .ast_data_i          (ast_data_i),
      .ast_startofpacket_i (ast_startofpacket_i),
      .ast_endofpacket_i   (ast_endofpacket_i),
      .ast_valid_i         (ast_valid_i),
      .ast_empty_i         (ast_empty_i),
      .ast_channel_i       (ast_channel_i),
      .ast_ready_o         (ast_ready_o),
      .ast_data_o          (ast_data_o),
      .ast_startofpacket_o (ast_startofpacket_o),
      .ast_endofpacket_o   (ast_endofpacket_o),
      .ast_valid_o         (ast_valid_o),
      .ast_empty_o         (ast_empty_o),
      .ast_channel_o       (ast_channel_o),
      .ast_ready_i         (ast_ready_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      int          nvalid;
      logic        sop;
      logic        eop;
      logic [2:0]  empty;
      logic [9:0]  chan;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   out_beats = 0;
   int   sop_cyc = 0;
   int   eop_cyc = 0;
   int   low_rdy = 0;
   logic [2:0] last_empty = '0;
   bit   rnd_ready = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] pbyte(input int seed, input int k);
      return 8'((seed * 37 + k * 11 + 5) & 255);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Ready pattern: constant 1, or random runs of 1..3 on / 1..3 off.
   always begin
      int  rcnt;
      bit  rstate;
      rcnt = 0;
      rstate = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) begin
            if (rcnt == 0) begin
               rstate = ~rstate;
               rcnt = $urandom_range(1, 3);
            end
            ast_ready_i = rstate;
            rcnt--;
         end else begin
            ast_ready_i = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on every output transfer, checks hold-stability under backpressure.
   always begin
      logic [79:0] prev_out;
      logic [79:0] cur_out;
      logic        pv, pr;
      logic [63:0] mask;
      exp_t        e;
      pv = 1'b0;
      pr = 1'b0;
      prev_out = '0;
      forever begin
         @(negedge clk);
         cur_out = {ast_valid_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o,
                    ast_channel_o, ast_data_o};
         if (srst_i) begin
            pv = 1'b0;
         end else begin
            if (pv && !pr) check("hold_stable", cur_out, prev_out);
            if (ast_valid_o && ast_ready_i) begin
               out_beats++;
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got data %0h, expected no beat", ast_data_o);
               end else begin
                  e = sb_q.pop_front();
                  mask = '0;
                  for (int i = 0; i < 8; i++) if (i < e.nvalid) mask[i*8 +: 8] = 8'hFF;
                  check("beat_data", ast_data_o & mask, e.data & mask);
                  check("beat_sop", ast_startofpacket_o, e.sop);
                  check("beat_eop", ast_endofpacket_o, e.eop);
                  check("beat_empty", ast_empty_o, e.empty);
                  check("beat_chan", ast_channel_o, e.chan);
                  if (ast_startofpacket_o) sop_cyc = cyc;
                  if (ast_endofpacket_o) begin
                     eop_cyc = cyc;
                     last_empty = ast_empty_o;
                  end
               end
            end
            if (ast_valid_o && !ast_ready_o) low_rdy++;
            pv = ast_valid_o;
            pr = ast_ready_i;
            prev_out = cur_out;
         end
      end
   end

   task automatic push_exp(input int len, input logic [9:0] chan, input int seed, input int npush);
      exp_t e;
      int   nb;
      nb = (len + 7) / 8;
      for (int j = 0; j < nb && j < npush; j++) begin
         e.data = '0;
         for (int i = 0; i < 8; i++)
            if (j * 8 + i < len) e.data[i*8 +: 8] = pbyte(seed, j * 8 + i);
         e.nvalid = (len - j * 8 > 8) ? 8 : len - j * 8;
         e.sop    = (j == 0);
         e.eop    = (j == nb - 1);
         e.empty  = (j == nb - 1) ? 3'(nb * 8 - len) : 3'd0;
         e.chan   = chan;
         sb_q.push_back(e);
      end
   endtask

   // Drives wide word w of a packet onto the inputs (valid asserted).
   task automatic set_word(input int len, input logic [9:0] chan, input int seed, input int w);
      int nw;
      nw = (len + 31) / 32;
      for (int i = 0; i < 32; i++)
         ast_data_i[i*8 +: 8] = (w * 32 + i < len) ? pbyte(seed, w * 32 + i) : 8'($urandom);
      ast_startofpacket_i = (w == 0);
      ast_endofpacket_i   = (w == nw - 1);
      ast_empty_i         = (w == nw - 1) ? 5'(nw * 32 - len) : 5'($urandom);
      ast_channel_i       = chan;
      ast_valid_i         = 1'b1;
   endtask

   task automatic wait_accept(input string name);
      bit acc;
      int t;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 300) begin
         @(negedge clk);
         acc = ast_ready_o;
         @(posedge clk);
         #1;
         t++;
      end
      if (!acc) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: ready_o never asserted, got 0 expected 1", name);
      end
   endtask

   task automatic send_pkt(input int len, input logic [9:0] chan, input int seed);
      int nw;
      nw = (len + 31) / 32;
      push_exp(len, chan, seed, 1000);
      for (int w = 0; w < nw; w++) begin
         set_word(len, chan, seed, w);
         wait_accept("input_accept");
      end
      ast_valid_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 600) begin
         @(posedge clk);
         t++;
      end
      check(name, 128'(sb_q.size()), 128'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int t;
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      n_fail++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 0);
      $fatal(1);
   end

   initial begin
      int base;
      int t;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_ready", ast_ready_o, 1'b0);
      check("rst_valid", ast_valid_o, 1'b0);
      check("rst_flags", {ast_startofpacket_o, ast_endofpacket_o}, 2'b00);
      check("rst_data", ast_data_o, 64'd0);
      check("rst_empty_chan", {ast_empty_o, ast_channel_o}, 13'd0);
      @(posedge clk);
      #1;
      srst_i = 1'b0;
      @(negedge clk);
      check("idle_ready", ast_ready_o, 1'b1);
      @(posedge clk);
      #1;

      // 128-byte packet, 16 back-to-back beats
      base = out_beats;
      send_pkt(128, 10'h155, 1);
      drain("p128_drain");
      check("p128_beats", 128'(out_beats - base), 128'd16);
      check("p128_b2b", 128'(eop_cyc - sop_cyc), 128'd15);
      check("p128_empty", last_empty, 3'd0);

      // 132-byte packet, last wide word carries 4 bytes
      base = out_beats;
      send_pkt(132, 10'h2a3, 2);
      drain("p132_drain");
      check("p132_beats", 128'(out_beats - base), 128'd17);
      check("p132_empty", last_empty, 3'd4);

      // 1-byte packet
      base = out_beats;
      send_pkt(1, 10'h3ff, 3);
      drain("p1_drain");
      check("p1_beats", 128'(out_beats - base), 128'd1);
      check("p1_empty", last_empty, 3'd7);

      // 40-byte packet: ready_o low on 3 of the 4 beats of the first word
      base = out_beats;
      low_rdy = 0;
      send_pkt(40, 10'h001, 4);
      drain("p40_drain");
      check("p40_beats", 128'(out_beats - base), 128'd5);
      check("p40_ready_low", 128'(low_rdy), 128'd3);

      // Five back-to-back 98-byte packets under random backpressure
      base = out_beats;
      rnd_ready = 1'b1;
      for (int p = 0; p < 5; p++) send_pkt(98, 10'($urandom_range(0, 1023)), 10 + p);
      drain("p98_drain");
      rnd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("p98_beats", 128'(out_beats - base), 128'd65);
      check("p98_empty", last_empty, 3'd6);

      // Reset in the middle of a 64-byte packet at narrow beat 2
      base = out_beats;
      push_exp(64, 10'h0f0, 20, 2);
      set_word(64, 10'h0f0, 20, 0);
      wait_accept("rst_pkt_accept");
      set_word(64, 10'h0f0, 20, 1);
      t = 0;
      while (out_beats < base + 2 && t < 100) begin
         @(posedge clk);
         t++;
      end
      check("rst_pre_beats", 128'(out_beats - base), 128'd2);
      #1;
      srst_i = 1'b1;
      ast_valid_i = 1'b0;
      #1;
      check("mid_rst_ready", ast_ready_o, 1'b0);
      @(posedge clk);
      #1;
      srst_i = 1'b0;
      @(negedge clk);
      check("post_rst_valid", ast_valid_o, 1'b0);
      check("post_rst_sb", 128'(sb_q.size()), 128'd0);
      @(posedge clk);
      #1;
      base = out_beats;
      send_pkt(8, 10'h00f, 21);
      drain("p8_drain");
      check("p8_beats", 128'(out_beats - base), 128'd1);
      check("p8_empty", last_empty, 3'd0);
      check("final_valid", ast_valid_o, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
